// File: rtl/ssd_scan_driver.sv
// Multiplexed N-digit seven-segment scan driver with per-frame snapshot, dead time, blink and zero blanking.
// Outputs are registered one cycle after the (cnt,idx) slot state; there is no backpressure and the scan is free-running while en=1.
module ssd_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int DEAD_CYC   = 4,
  parameter int BLINK_DIV  = 64,
  parameter int HEX_EN     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] nums,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic                    lz_suppress,
  output logic [7:0]              ssd_o,
  output logic [NUM_DIGITS-1:0]   ssd_ctl,
  output logic                    frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEAD_END   = CW'(DEAD_CYC);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [BW-1:0]           blink_cnt;
  logic                    phase;
  logic [4*NUM_DIGITS-1:0] nums_s;
  logic [NUM_DIGITS-1:0]   dp_s;
  logic [NUM_DIGITS-1:0]   blank_s;
  logic [NUM_DIGITS-1:0]   blink_s;

  logic                    slot_last;
  logic                    frame_end;
  logic                    snap;
  logic [3:0]              cur_nib;
  logic [7:0]              cur_glyph;
  logic [NUM_DIGITS-1:0]   upper_zero;
  logic                    lz_dark;
  logic                    dark;
  logic [NUM_DIGITS-1:0]   anode_sel;

  // Segment order {a,b,c,d,e,f,g,dp}, active-low; dp bit is left off here.
  function automatic logic [7:0] glyph(input logic [3:0] n);
    logic [7:0] g;
    case (n)
      4'h0: g = 8'h03;
      4'h1: g = 8'h9F;
      4'h2: g = 8'h25;
      4'h3: g = 8'h0D;
      4'h4: g = 8'h99;
      4'h5: g = 8'h49;
      4'h6: g = 8'h41;
      4'h7: g = 8'h1F;
      4'h8: g = 8'h01;
      4'h9: g = 8'h09;
      4'hA: g = 8'h11;
      4'hB: g = 8'hC1;
      4'hC: g = 8'h63;
      4'hD: g = 8'h85;
      4'hE: g = 8'h61;
      default: g = 8'h71;
    endcase
    if (HEX_EN == 0 && n > 4'h9) begin
      g = 8'hFF;
    end
    return g;
  endfunction

  assign slot_last = (cnt == CNT_LAST);
  assign frame_end = en && slot_last && (idx == IDX_LAST);
  assign snap      = en && (cnt == '0) && (idx == '0);
  assign cur_nib   = nums_s[{idx, 2'b00} +: 4];
  assign cur_glyph = glyph(cur_nib);
  assign anode_sel = NUM_DIGITS'(1) << idx;

  // upper_zero[i]: every shadow nibble from position i up to the top is zero.
  always_comb begin
    logic acc;
    acc        = 1'b1;
    upper_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc           = acc & (nums_s[4*i +: 4] == 4'h0);
      upper_zero[i] = acc;
    end
  end

  assign lz_dark = lz_suppress && (idx != '0) && upper_zero[idx];
  assign dark    = blank_s[idx] || (blink_s[idx] && phase) || lz_dark;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      blink_cnt  <= '0;
      phase      <= 1'b0;
      nums_s     <= '0;
      dp_s       <= '0;
      blank_s    <= '0;
      blink_s    <= '0;
      ssd_o      <= 8'hFF;
      ssd_ctl    <= '1;
      frame_done <= 1'b0;
    end else if (!en) begin
      // Scan restarts from slot 0 on re-enable; blink timing is frozen.
      cnt        <= '0;
      idx        <= '0;
      ssd_o      <= 8'hFF;
      ssd_ctl    <= '1;
      frame_done <= 1'b0;
    end else begin
      if (slot_last) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end

      if (snap) begin
        nums_s  <= nums;
        dp_s    <= dp;
        blank_s <= blank;
        blink_s <= blink;
      end

      frame_done <= frame_end;
      if (frame_end) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end

      // Dead time at slot start keeps the previous digit from ghosting into this one.
      if (cnt < DEAD_END) begin
        ssd_o   <= 8'hFF;
        ssd_ctl <= '1;
      end else begin
        ssd_ctl <= ~anode_sel;
        ssd_o   <= dark ? 8'hFF : {cur_glyph[7:1], ~dp_s[idx]};
      end
    end
  end

endmodule
